// File: rtl/width_splitter.sv
// rtl/width_splitter.sv - splits one wide backward word into up to RATIO forward beats
module width_splitter #(
    parameter int DATA_W    = 32,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0,
    localparam int IDX_W    = (RATIO > 2) ? $clog2(RATIO) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W*RATIO-1:0] bwd_data,
    input  logic [IDX_W-1:0]        bwd_len,
    input  logic                    bwd_vld,
    output logic                    bwd_rdy,
    output logic [DATA_W-1:0]       fwd_data,
    output logic [IDX_W-1:0]        fwd_idx,
    output logic                    fwd_last,
    output logic                    fwd_vld,
    input  logic                    fwd_rdy
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_BUSY  = 1'b1
    } state_t;

    // Highest legal beat index; also the reversal base for MSB-first order.
    localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(RATIO - 1);

    state_t                    state;
    state_t                    state_nxt;
    logic [DATA_W*RATIO-1:0]   buffer;
    logic [IDX_W-1:0]          cnt;
    logic [IDX_W-1:0]          len;
    logic [IDX_W-1:0]          len_clamped;
    logic [IDX_W-1:0]          beat_sel;
    logic                      is_last;
    logic                      capture;

    // The current beat is the final one of the held word.
    assign is_last = (cnt == len);

    // A length field can only exceed the beat count when RATIO is not a power of two.
    generate
        if ((1 << IDX_W) == RATIO) begin : g_no_clamp
            assign len_clamped = bwd_len;
        end else begin : g_clamp
            assign len_clamped = (bwd_len > MAX_LEN) ? MAX_LEN : bwd_len;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshakes; bwd_rdy in BUSY only opens on the last-beat handshake.
    always_comb begin
        state_nxt = state;
        bwd_rdy   = 1'b0;
        fwd_vld   = 1'b0;
        capture   = 1'b0;
        case (state)
            S_EMPTY: begin
                bwd_rdy = 1'b1;
                if (bwd_vld) begin
                    capture   = 1'b1;
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                fwd_vld = 1'b1;
                if (fwd_rdy && is_last) begin
                    bwd_rdy = 1'b1;
                    if (bwd_vld) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = S_EMPTY;
                    end
                end
            end
            default: begin
                state_nxt = S_EMPTY;
            end
        endcase
    end

    // Word buffer, length and beat counter; a capture always restarts at beat 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer <= '0;
            len    <= '0;
            cnt    <= '0;
        end else if (capture) begin
            buffer <= bwd_data;
            len    <= len_clamped;
            cnt    <= '0;
        end else if (state == S_BUSY && fwd_rdy) begin
            cnt <= is_last ? '0 : cnt + 1'b1;
        end
    end

    // Physical beat position inside the buffer for the current emission index.
    assign beat_sel = MSB_FIRST ? (MAX_LEN - cnt) : cnt;

    // Beat multiplexer over the buffer slices.
    always_comb begin
        fwd_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (beat_sel == IDX_W'(i)) begin
                fwd_data = buffer[i*DATA_W +: DATA_W];
            end
        end
    end

    assign fwd_idx  = cnt;
    assign fwd_last = fwd_vld & is_last;

endmodule

// File: tb/tb_width_splitter.sv
// tb/tb_width_splitter.sv - self-checking bench for width_splitter
module tb_width_splitter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] bwd_data [N];
    logic [1:0]  bwd_len  [N];
    logic        bwd_vld  [N];
    logic        bwd_rdy  [N];
    logic [7:0]  fwd_data [N];
    logic [1:0]  fwd_idx  [N];
    logic        fwd_last [N];
    logic        fwd_vld  [N];
    logic        fwd_rdy  [N];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // model entry: {last, idx[1:0], data[7:0]}
    logic [10:0] expq    [N][$];
    logic [10:0] log_ent [N][$];
    int          log_cyc [N][$];
    int          acc_cyc [N][$];
    logic        accepted [N];
    logic        captured [N];

    always #5 clk = ~clk;

    width_splitter #(.DATA_W(8), .RATIO(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_n(rst_n),
        .bwd_data(bwd_data[0]), .bwd_len(bwd_len[0]), .bwd_vld(bwd_vld[0]), .bwd_rdy(bwd_rdy[0]),
        .fwd_data(fwd_data[0]), .fwd_idx(fwd_idx[0]), .fwd_last(fwd_last[0]),
        .fwd_vld(fwd_vld[0]), .fwd_rdy(fwd_rdy[0])
    );

    width_splitter #(.DATA_W(8), .RATIO(4), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_n(rst_n),
        .bwd_data(bwd_data[1]), .bwd_len(bwd_len[1]), .bwd_vld(bwd_vld[1]), .bwd_rdy(bwd_rdy[1]),
        .fwd_data(fwd_data[1]), .fwd_idx(fwd_idx[1]), .fwd_last(fwd_last[1]),
        .fwd_vld(fwd_vld[1]), .fwd_rdy(fwd_rdy[1])
    );

    width_splitter #(.DATA_W(8), .RATIO(3), .MSB_FIRST(1'b0)) u_r3 (
        .clk(clk), .rst_n(rst_n),
        .bwd_data(bwd_data[2][23:0]), .bwd_len(bwd_len[2]), .bwd_vld(bwd_vld[2]), .bwd_rdy(bwd_rdy[2]),
        .fwd_data(fwd_data[2]), .fwd_idx(fwd_idx[2]), .fwd_last(fwd_last[2]),
        .fwd_vld(fwd_vld[2]), .fwd_rdy(fwd_rdy[2])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d actual=0x%0h expected=0x%0h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic int ratio_of(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    // Expand an accepted word into its expected beat sequence.
    task automatic push_word(input int i, input logic [31:0] w, input logic [1:0] ln);
        int r;
        int n;
        int b;
        logic [7:0] d;
        r = ratio_of(i);
        n = (int'(ln) > r - 1) ? r : int'(ln) + 1;
        for (int k = 0; k < n; k++) begin
            b = (i == 1) ? (r - 1 - k) : k;
            d = 8'(w >> (8 * b));
            expq[i].push_back({(k == n - 1), 2'(k), d});
        end
    endtask

    // Compare process: sampled just before each rising edge.
    initial begin
        logic        ev;
        logic        ebr;
        logic [10:0] hd;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    chk("rst_fwd_vld", i, 32'(fwd_vld[i]), 32'd0);
                    chk("rst_fwd_last", i, 32'(fwd_last[i]), 32'd0);
                    chk("rst_fwd_idx", i, 32'(fwd_idx[i]), 32'd0);
                    chk("rst_fwd_data", i, 32'(fwd_data[i]), 32'd0);
                    expq[i].delete();
                    accepted[i] = 1'b0;
                    captured[i] = 1'b0;
                end else begin
                    ev = (expq[i].size() != 0);
                    hd = ev ? expq[i][0] : 11'd0;
                    chk("fwd_vld", i, 32'(fwd_vld[i]), 32'(ev));
                    if (ev) begin
                        chk("fwd_data", i, 32'(fwd_data[i]), 32'(hd[7:0]));
                        chk("fwd_idx", i, 32'(fwd_idx[i]), 32'(hd[9:8]));
                        chk("fwd_last", i, 32'(fwd_last[i]), 32'(hd[10]));
                    end else begin
                        chk("idle_fwd_last", i, 32'(fwd_last[i]), 32'd0);
                        if (!captured[i]) chk("idle_fwd_data", i, 32'(fwd_data[i]), 32'd0);
                    end
                    ebr = !ev || (fwd_rdy[i] && hd[10]);
                    chk("bwd_rdy", i, 32'(bwd_rdy[i]), 32'(ebr));
                    if (ev && fwd_rdy[i]) begin
                        void'(expq[i].pop_front());
                        log_ent[i].push_back(hd);
                        log_cyc[i].push_back(cyc);
                    end
                    accepted[i] = bwd_vld[i] && ebr;
                    if (accepted[i]) begin
                        push_word(i, bwd_data[i], bwd_len[i]);
                        captured[i] = 1'b1;
                        acc_cyc[i].push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic send(input int i, input logic [31:0] w, input logic [1:0] ln);
        bit ok;
        @(negedge clk);
        bwd_vld[i]  = 1'b1;
        bwd_data[i] = w;
        bwd_len[i]  = ln;
        ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            if (accepted[i]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout inst=%0d word=0x%0h not accepted", i, w);
        end
    endtask

    // Deassert valid and scramble the now-ignored word inputs.
    task automatic drop(input int i);
        @(negedge clk);
        bwd_vld[i]  = 1'b0;
        bwd_data[i] = $urandom;
        bwd_len[i]  = 2'($urandom_range(0, 3));
    endtask

    task automatic drain(input int i);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (expq[i].size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout inst=%0d pending=%0d", i, expq[i].size());
        end
    endtask

    task automatic clear_logs(input int i);
        log_ent[i].delete();
        log_cyc[i].delete();
        acc_cyc[i].delete();
    endtask

    initial begin
        logic [7:0] exp_b [4];
        int a;
        bit ok;
        for (int i = 0; i < N; i++) begin
            bwd_data[i] = '0;
            bwd_len[i]  = '0;
            bwd_vld[i]  = 1'b0;
            fwd_rdy[i]  = 1'b1;
            accepted[i] = 1'b0;
            captured[i] = 1'b0;
        end
        #1;
        chk("reset_vld_lit", 0, 32'(fwd_vld[0]), 32'd0);
        chk("reset_data_lit", 0, 32'(fwd_data[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // LSB-first 4-beat word
        clear_logs(0);
        send(0, 32'h44332211, 2'd3);
        drop(0);
        drain(0);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk("lsb_count", 0, 32'(log_ent[0].size()), 32'd4);
        if (log_ent[0].size() == 4 && acc_cyc[0].size() == 1) begin
            a = acc_cyc[0][0];
            for (int k = 0; k < 4; k++) begin
                chk("lsb_beat", 0, 32'(log_ent[0][k][7:0]), 32'(exp_b[k]));
                chk("lsb_last", 0, 32'(log_ent[0][k][10]), 32'(k == 3));
                chk("lsb_cycle", 0, 32'(log_cyc[0][k]), 32'(a + 1 + k));
            end
        end

        // MSB-first 4-beat word
        clear_logs(1);
        send(1, 32'h44332211, 2'd3);
        drop(1);
        drain(1);
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
        chk("msb_count", 1, 32'(log_ent[1].size()), 32'd4);
        if (log_ent[1].size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("msb_beat", 1, 32'(log_ent[1][k][7:0]), 32'(exp_b[k]));
                chk("msb_idx", 1, 32'(log_ent[1][k][9:8]), 32'(k));
            end
        end

        // Back-to-back words, no bubble
        clear_logs(0);
        send(0, 32'hDDCCBBAA, 2'd1);
        send(0, 32'h44332211, 2'd0);
        drop(0);
        drain(0);
        exp_b = '{8'hAA, 8'hBB, 8'h11, 8'h00};
        chk("b2b_count", 0, 32'(log_ent[0].size()), 32'd3);
        if (log_ent[0].size() == 3 && acc_cyc[0].size() == 2) begin
            for (int k = 0; k < 3; k++) begin
                chk("b2b_beat", 0, 32'(log_ent[0][k][7:0]), 32'(exp_b[k]));
                chk("b2b_cycle", 0, 32'(log_cyc[0][k]), 32'(log_cyc[0][0] + k));
            end
            chk("b2b_accept_on_bb", 0, 32'(acc_cyc[0][1]), 32'(log_cyc[0][1]));
        end

        // Stalls with fwd_rdy pattern 1,0,0,1
        clear_logs(0);
        send(0, 32'h44332211, 2'd3);
        drop(0);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            fwd_rdy[0] = ((c % 4) == 0) || ((c % 4) == 3);
        end
        @(negedge clk);
        fwd_rdy[0] = 1'b1;
        drain(0);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk("stall_count", 0, 32'(log_ent[0].size()), 32'd4);
        if (log_ent[0].size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("stall_beat", 0, 32'(log_ent[0][k][7:0]), 32'(exp_b[k]));
            end
        end

        // RATIO=3 length clamp
        clear_logs(2);
        send(2, 32'h00332211, 2'd3);
        drop(2);
        drain(2);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h00};
        chk("clamp_count", 2, 32'(log_ent[2].size()), 32'd3);
        if (log_ent[2].size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk("clamp_beat", 2, 32'(log_ent[2][k][7:0]), 32'(exp_b[k]));
                chk("clamp_last", 2, 32'(log_ent[2][k][10]), 32'(k == 2));
            end
        end

        // Asynchronous reset mid-word
        clear_logs(0);
        send(0, 32'h44332211, 2'd3);
        drop(0);
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (log_ent[0].size() >= 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midword_progress", 0, 32'(ok), 32'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_vld", 0, 32'(fwd_vld[0]), 32'd0);
        chk("async_rst_idx", 0, 32'(fwd_idx[0]), 32'd0);
        chk("async_rst_data", 0, 32'(fwd_data[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs(0);
        send(0, 32'h88776655, 2'd3);
        drop(0);
        drain(0);
        chk("post_rst_count", 0, 32'(log_ent[0].size()), 32'd4);
        if (log_ent[0].size() == 4) begin
            chk("post_rst_first_data", 0, 32'(log_ent[0][0][7:0]), 32'h55);
            chk("post_rst_first_idx", 0, 32'(log_ent[0][0][9:8]), 32'd0);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/width_splitter.md
WIDTH_SPLITTER -- requirements
Module: width_splitter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning forward beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning max beats per backward word; legal range 2..16.
REQ-003 SHALL have parameter MSB_FIRST, default 0, meaning beat order: 0 = bits [DATA_W-1:0] first, 1 = most significant beat first.
REQ-004 SHALL have localparam IDX_W = max(1, clog2(RATIO)).
REQ-005 clk  input  1  clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 bwd_data  input  DATA_W*RATIO  wide word to split.
REQ-008 bwd_len  input  IDX_W  number of beats minus one (0 = 1 beat).
REQ-009 bwd_vld  input  1  backward word valid.
REQ-010 bwd_rdy  output  1  backward word accepted when bwd_vld & bwd_rdy (bwd_hsk).
REQ-011 fwd_data  output  DATA_W  current beat.
REQ-012 fwd_idx  output  IDX_W  position of current beat within the word (0 = first emitted).
REQ-013 fwd_last  output  1  current beat is the final beat of the word.
REQ-014 fwd_vld  output  1  beat valid.
REQ-015 fwd_rdy  input  1  beat consumed when fwd_vld & fwd_rdy (fwd_hsk).

Function
REQ-016 SHALL hold one wide word in an internal buffer plus a beat counter cnt (IDX_W) and length register len (IDX_W).
REQ-017 SHALL implement two states: EMPTY (fwd_vld=0) and BUSY (fwd_vld=1).
REQ-018 EMPTY: bwd_rdy=1; on bwd_hsk capture bwd_data, len<=bwd_len, cnt<=0, go BUSY; fwd_vld rises the next cycle (latency 1).
REQ-019 BUSY: fwd_data = beat cnt of buffer (LSB order) or beat RATIO-1-cnt (MSB_FIRST=1); fwd_idx=cnt; fwd_last=(cnt==len).
REQ-020 BUSY, fwd_hsk with fwd_last=0: cnt<=cnt+1, stay BUSY; buffer unchanged.
REQ-021 BUSY: bwd_rdy = fwd_hsk & fwd_last (combinational from fwd_rdy); no other path asserts bwd_rdy in BUSY.
REQ-022 BUSY, last-beat fwd_hsk with bwd_hsk: capture new word, cnt<=0, stay BUSY; no bubble between words.
REQ-023 BUSY, last-beat fwd_hsk without bwd_vld: go EMPTY, cnt<=0.
REQ-024 bwd_len > RATIO-1 (non-power-of-2 RATIO) SHALL be clamped to RATIO-1 at capture.
REQ-025 fwd_vld, fwd_data, fwd_idx, fwd_last SHALL be held stable while fwd_vld=1 and fwd_rdy=0.
REQ-026 bwd_data and bwd_len SHALL be sampled only on bwd_hsk; changes at other times have no effect.
REQ-027 Throughput: one beat per cycle with fwd_rdy held 1; a word of N beats occupies exactly N cycles.
REQ-028 fwd_last SHALL be 0 whenever fwd_vld=0.

Reset
REQ-029 On rst_n low, immediately and independent of clk: state EMPTY, fwd_vld=0, fwd_last=0, fwd_idx=0, cnt=0, len=0.
REQ-030 Buffer SHALL reset to 0, so fwd_data=0 during and after reset until the first capture.
REQ-031 Reset asserted mid-word SHALL discard remaining beats; after release the first bwd_hsk starts a fresh word at idx 0.

Verification
REQ-032 DATA_W=8, RATIO=4, MSB_FIRST=0: bwd_data=0x44332211, bwd_len=3, fwd_rdy=1 -> beats 0x11,0x22,0x33,0x44 on 4 consecutive cycles starting 1 cycle after hsk, fwd_last only on 0x44.
REQ-033 Same word with MSB_FIRST=1 -> beats 0x44,0x33,0x22,0x11, fwd_idx 0..3.
REQ-034 Back-to-back words 0xDDCCBBAA (len 1) then 0x44332211 (len 0), bwd_vld held 1 -> fwd stream AA,BB,11 with no idle cycle; bwd_rdy=1 only in the cycle of beat BB.
REQ-035 fwd_rdy toggling 1,0,0,1,... during a 4-beat word -> outputs stable while stalled, no beat lost or repeated, bwd_rdy stays 0 until last-beat hsk.
REQ-036 RATIO=3, bwd_len=3 -> clamped to 3 beats, fwd_last on idx 2.
REQ-037 rst_n pulsed low after beat 1 of a 4-beat word -> fwd_vld=0 asynchronously; next word after release emits from idx 0.
